// File: rtl/axi_bresp_gen.sv
// AXI write-response generator: tracks accepted AW requests in a circular buffer, counts W beats
// per transaction and returns in-order B responses (OKAY / SLVERR on length mismatch / DECERR).
module axi_bresp_gen #(
  parameter int unsigned AXI_ID_W   = 16,
  parameter int unsigned AXI_USER_W = 6,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // AW channel
  input  logic [AXI_ID_W-1:0]     awid_i,
  input  logic [AXI_USER_W-1:0]   awuser_i,
  input  logic [7:0]              awlen_i,
  input  logic                    awerr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  // W handshake
  input  logic                    wlast_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic                    w_beat_o,
  // B channel
  output logic [AXI_ID_W-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  output logic [AXI_USER_W-1:0]   buser_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  // Status
  output logic [$clog2(DEPTH):0]  outstanding_o,
  output logic                    full_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef logic [PtrW-1:0] ptr_t;

  // Entry storage; contents are qualified by the pointers so no reset is needed.
  logic [AXI_ID_W-1:0]   id_q   [DEPTH];
  logic [AXI_USER_W-1:0] user_q [DEPTH];
  logic [7:0]            len_q  [DEPTH];
  logic                  err_q  [DEPTH];
  logic [1:0]            resp_q [DEPTH];

  ptr_t       aw_ptr_q, aw_ptr_d;
  ptr_t       w_ptr_q, w_ptr_d;
  ptr_t       b_ptr_q, b_ptr_d;
  logic [8:0] beat_cnt_q, beat_cnt_d;

  logic [IdxW-1:0] aw_idx, w_idx, b_idx;
  ptr_t            occupancy;
  logic            full;
  logic            w_pending, b_pending;
  logic            aw_hs, w_hs, wlast_hs, b_hs;
  logic [1:0]      status;

  assign aw_idx = aw_ptr_q[IdxW-1:0];
  assign w_idx  = w_ptr_q[IdxW-1:0];
  assign b_idx  = b_ptr_q[IdxW-1:0];

  assign occupancy = aw_ptr_q - b_ptr_q;
  assign full      = (occupancy == ptr_t'(DEPTH));
  assign w_pending = (w_ptr_q != aw_ptr_q);
  assign b_pending = (b_ptr_q != w_ptr_q);

  assign aw_hs    = awvalid_i & ~full;
  assign w_hs     = wvalid_i & w_pending;
  assign wlast_hs = w_hs & wlast_i;
  assign b_hs     = b_pending & bready_i;

  // beat_cnt_q holds beats before the current one, so a correct burst ends with cnt == len.
  always_comb begin
    status = RespOkay;
    if (err_q[w_idx]) begin
      status = RespDecErr;
    end else if (beat_cnt_q != {1'b0, len_q[w_idx]}) begin
      status = RespSlvErr;
    end
  end

  always_comb begin
    aw_ptr_d   = aw_ptr_q;
    w_ptr_d    = w_ptr_q;
    b_ptr_d    = b_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (aw_hs) begin
      aw_ptr_d = aw_ptr_q + ptr_t'(1);
    end
    if (wlast_hs) begin
      w_ptr_d    = w_ptr_q + ptr_t'(1);
      beat_cnt_d = '0;
    end else if (w_hs) begin
      // Saturate so an endless overrun can never alias back onto len+1.
      beat_cnt_d = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + 9'd1;
    end
    if (b_hs) begin
      b_ptr_d = b_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_ptr_q   <= '0;
      w_ptr_q    <= '0;
      b_ptr_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      aw_ptr_q   <= aw_ptr_d;
      w_ptr_q    <= w_ptr_d;
      b_ptr_q    <= b_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // aw_idx only equals w_idx/b_idx of a live entry when full, and no push happens then.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      id_q[aw_idx]   <= awid_i;
      user_q[aw_idx] <= awuser_i;
      len_q[aw_idx]  <= awlen_i;
      err_q[aw_idx]  <= awerr_i;
    end
    if (wlast_hs) begin
      resp_q[w_idx] <= status;
    end
  end

  assign awready_o     = ~full;
  assign wready_o      = w_pending;
  assign w_beat_o      = w_hs & ~err_q[w_idx];
  assign bvalid_o      = b_pending;
  assign bid_o         = b_pending ? id_q[b_idx]   : '0;
  assign buser_o       = b_pending ? user_q[b_idx] : '0;
  assign bresp_o       = b_pending ? resp_q[b_idx] : RespOkay;
  assign outstanding_o = occupancy;
  assign full_o        = full;

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= ptr_t'(DEPTH));

  a_ptr_order: assert property (@(posedge clk) disable iff (!rst_n)
    ptr_t'(w_ptr_q - b_ptr_q) <= occupancy);

  a_b_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bvalid_o && !bready_i) |=> (bvalid_o && $stable(bid_o) && $stable(buser_o)
                                 && $stable(bresp_o)));

endmodule
